hazard_sequencer: RTL

- Pipeline sequencing controller for the 5-stage RISC-V core.
- Owns start-up, load-use bubbles, taken-branch flushes and multi-cycle data-memory waits.
- Drives `noop_i` of the main decoder, the PC/IF-ID write enables, the IF-ID flush and a global pipeline freeze.
- Sits beside the ID stage; consumes ID/EX hazard info and the data-memory handshake.

---
 rtl/hazard_sequencer_pkg.sv | 18 +
 rtl/hazard_sequencer_if.sv | 41 ++++
 rtl/hazard_sequencer_hazard_detect.sv | 22 ++
 rtl/hazard_sequencer.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/hazard_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_sequencer_pkg
// Description : Shared state encodings and widths for the hazard sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_sequencer_pkg;

    localparam int c_STATE_W = 2;
    localparam int c_REG_W   = 5;

    localparam logic [c_STATE_W-1:0] c_ST_IDLE     = 2'd0;
    localparam logic [c_STATE_W-1:0] c_ST_RUN      = 2'd1;
    localparam logic [c_STATE_W-1:0] c_ST_MEM_WAIT = 2'd2;
    localparam logic [c_STATE_W-1:0] c_ST_HALT     = 2'd3;

endpackage
`default_nettype wire

// File: rtl/hazard_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_sequencer_if
// Description : Hazard inputs and pipeline control outputs of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_sequencer_if;
    import hazard_sequencer_pkg::*;

    logic                 start_i;
    logic [c_REG_W-1:0]   IFID_rs1_i;
    logic [c_REG_W-1:0]   IFID_rs2_i;
    logic [c_REG_W-1:0]   IDEX_rd_i;
    logic                 IDEX_MemRead_i;
    logic                 branch_taken_i;
    logic                 mem_req_i;
    logic                 mem_ack_i;
    logic                 pc_write_o;
    logic                 ifid_write_o;
    logic                 noop_o;
    logic                 flush_o;
    logic                 pipe_stall_o;
    logic                 err_o;
    logic [c_STATE_W-1:0] state_o;

    modport master (
        output start_i, IFID_rs1_i, IFID_rs2_i, IDEX_rd_i, IDEX_MemRead_i,
               branch_taken_i, mem_req_i, mem_ack_i,
        input  pc_write_o, ifid_write_o, noop_o, flush_o, pipe_stall_o,
               err_o, state_o
    );

    modport slave (
        input  start_i, IFID_rs1_i, IFID_rs2_i, IDEX_rd_i, IDEX_MemRead_i,
               branch_taken_i, mem_req_i, mem_ack_i,
        output pc_write_o, ifid_write_o, noop_o, flush_o, pipe_stall_o,
               err_o, state_o
    );

endinterface
`default_nettype wire

// File: rtl/hazard_sequencer_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Combinational load-use hazard compare between ID and EX.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
    import hazard_sequencer_pkg::*;
(
    input  logic [c_REG_W-1:0] i_rs1,
    input  logic [c_REG_W-1:0] i_rs2,
    input  logic [c_REG_W-1:0] i_rd,
    input  logic               i_mem_read,
    output logic               o_lu_hazard
);

    // x0 is never a real producer, so a lw to x0 cannot create a hazard
    assign o_lu_hazard = i_mem_read && (i_rd != '0) &&
                         ((i_rd == i_rs1) || (i_rd == i_rs2));

endmodule
`default_nettype wire

// File: rtl/hazard_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : hazard_sequencer
// Description : Pipeline sequencing FSM: start-up, load-use bubbles, branch
//               flushes, data-memory waits with timeout. Optional performance
//               counters are enabled by defining HAZARD_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_sequencer
    import hazard_sequencer_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 255,
    parameter int WCNT_W       = 8,
    parameter int PERF_W       = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    hazard_sequencer_if.slave bus
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] lu_stall_cnt_o,
    output logic [PERF_W-1:0] mem_wait_cnt_o,
    output logic [PERF_W-1:0] flush_cnt_o
`endif
);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_nxt;
    logic [WCNT_W-1:0]    r_wait_cnt;
    logic [WCNT_W-1:0]    w_wait_cnt_nxt;
    logic                 r_err;
    logic                 w_err_nxt;
    logic                 w_lu_hazard;
    logic                 w_mem_hold;

    hazard_detect u_hazard_detect (
        .i_rs1       (bus.IFID_rs1_i),
        .i_rs2       (bus.IFID_rs2_i),
        .i_rd        (bus.IDEX_rd_i),
        .i_mem_read  (bus.IDEX_MemRead_i),
        .o_lu_hazard (w_lu_hazard)
    );

    // A same-cycle ack is a zero-wait access and never holds the pipe
    assign w_mem_hold = bus.mem_req_i && !bus.mem_ack_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= c_ST_IDLE;
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_err      <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_wait_cnt_nxt   = r_wait_cnt;
        w_err_nxt        = r_err;
        bus.pc_write_o   = 1'b0;
        bus.ifid_write_o = 1'b0;
        bus.noop_o       = 1'b0;
        bus.flush_o      = 1'b0;
        bus.pipe_stall_o = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                bus.noop_o       = 1'b1;
                bus.pipe_stall_o = 1'b1;
                if (bus.start_i) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (w_mem_hold) begin
                    bus.pipe_stall_o = 1'b1;
                    w_state_nxt      = c_ST_MEM_WAIT;
                    w_wait_cnt_nxt   = WCNT_W'(1);
                end else if (w_lu_hazard) begin
                    // Branch re-resolves next cycle with forwarded data
                    bus.noop_o = 1'b1;
                end else begin
                    bus.pc_write_o   = 1'b1;
                    bus.ifid_write_o = 1'b1;
                    bus.flush_o      = bus.branch_taken_i;
                end
            end
            c_ST_MEM_WAIT: begin
                bus.pipe_stall_o = 1'b1;
                if (bus.mem_ack_i) begin
                    w_state_nxt    = c_ST_RUN;
                    w_wait_cnt_nxt = '0;
                end else if (r_wait_cnt == WCNT_W'(MEM_WAIT_MAX)) begin
                    w_state_nxt = c_ST_HALT;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + WCNT_W'(1);
                end
            end
            c_ST_HALT: begin
                bus.noop_o       = 1'b1;
                bus.pipe_stall_o = 1'b1;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    assign bus.err_o   = r_err;
    assign bus.state_o = r_state;

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] r_lu_cnt;
    logic [PERF_W-1:0] r_mw_cnt;
    logic [PERF_W-1:0] r_fl_cnt;

    // Counters stick at all-ones rather than wrapping
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lu_cnt <= '0;
            r_mw_cnt <= '0;
            r_fl_cnt <= '0;
        end else begin
            if ((r_state == c_ST_RUN) && !w_mem_hold && w_lu_hazard && !(&r_lu_cnt)) begin
                r_lu_cnt <= r_lu_cnt + PERF_W'(1);
            end
            if ((r_state == c_ST_MEM_WAIT) && !(&r_mw_cnt)) begin
                r_mw_cnt <= r_mw_cnt + PERF_W'(1);
            end
            if (bus.flush_o && !(&r_fl_cnt)) begin
                r_fl_cnt <= r_fl_cnt + PERF_W'(1);
            end
        end
    end

    assign lu_stall_cnt_o = r_lu_cnt;
    assign mem_wait_cnt_o = r_mw_cnt;
    assign flush_cnt_o    = r_fl_cnt;
`endif

endmodule
`default_nettype wire
